pipe_hazard_ctrl: RTL and testbench

//  Sequences the 5-stage pipeline registers (F/D, D/E, E/M, M/W) and the PC register.

---
 rtl/pipe_ctrl_pkg.sv | 23 ++
 rtl/pipe_hazard_ctrl_if.sv | 31 +++
 rtl/sat_counter.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and helpers for the pipeline hazard controller
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DISCARD  = 2'd2
  } ctrl_state_t;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } fwd_sel_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // A producer "matches" a source only if it writes a non-x0 register equal to it.
  function automatic logic reg_match(input logic we, input logic [4:0] rd, input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline status inputs and stage control outputs of the hazard controller
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs1_d, rs2_d, rs1_e, rs2_e;
  logic [4:0]       rd_e, rd_m, rd_w;
  logic             regwrite_e, regwrite_m, regwrite_w;
  logic             memread_e, pcsrc_e, imem_ready_f;
  logic             dmem_req_m, dmem_ready_m;
  logic             en_pc;
  logic             en_fd, clr_fd, en_de, clr_de;
  logic             en_em, clr_em, en_mw, clr_mw;
  logic [1:0]       fwd_a_e, fwd_b_e;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    output regwrite_e, regwrite_m, regwrite_w,
    output memread_e, pcsrc_e, imem_ready_f, dmem_req_m, dmem_ready_m,
    input  en_pc, en_fd, clr_fd, en_de, clr_de, en_em, clr_em, en_mw, clr_mw,
    input  fwd_a_e, fwd_b_e, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    input  regwrite_e, regwrite_m, regwrite_w,
    input  memread_e, pcsrc_e, imem_ready_f, dmem_req_m, dmem_ready_m,
    output en_pc, en_fd, clr_fd, en_de, clr_de, en_em, clr_em, en_mw, clr_mw,
    output fwd_a_e, fwd_b_e, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline register sequencing: stalls, flushes, memory waits, forwarding
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  ctrl_state_t r_st, w_st_nxt;
  fwd_sel_t    w_fwd_a, w_fwd_b;
  logic        w_lu_haz, w_raw_d, w_dmem_wait, w_flush_inc;
  logic        w_en_pc, w_en_fd, w_clr_fd, w_en_de, w_clr_de;
  logic        w_en_em, w_en_mw;

  always_comb begin
    w_fwd_a = FWD_NONE;
    w_fwd_b = FWD_NONE;
    if (FWD_EN) begin
      if (reg_match(bus.regwrite_m, bus.rd_m, bus.rs1_e))      w_fwd_a = FWD_M;
      else if (reg_match(bus.regwrite_w, bus.rd_w, bus.rs1_e)) w_fwd_a = FWD_W;
      if (reg_match(bus.regwrite_m, bus.rd_m, bus.rs2_e))      w_fwd_b = FWD_M;
      else if (reg_match(bus.regwrite_w, bus.rd_w, bus.rs2_e)) w_fwd_b = FWD_W;
    end
  end

  // Without forwarding, any in-flight producer of a D-stage source must drain first.
  assign w_raw_d = reg_match(bus.regwrite_e, bus.rd_e, bus.rs1_d) ||
                   reg_match(bus.regwrite_e, bus.rd_e, bus.rs2_d) ||
                   reg_match(bus.regwrite_m, bus.rd_m, bus.rs1_d) ||
                   reg_match(bus.regwrite_m, bus.rd_m, bus.rs2_d) ||
                   reg_match(bus.regwrite_w, bus.rd_w, bus.rs1_d) ||
                   reg_match(bus.regwrite_w, bus.rd_w, bus.rs2_d);

  assign w_lu_haz = (bus.memread_e && (bus.rd_e != 5'd0) &&
                     ((bus.rd_e == bus.rs1_d) || (bus.rd_e == bus.rs2_d))) ||
                    (!FWD_EN && w_raw_d);

  assign w_dmem_wait = bus.dmem_req_m && !bus.dmem_ready_m;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_st <= RUN;
    else        r_st <= w_st_nxt;
  end

  always_comb begin
    w_st_nxt    = r_st;
    w_en_pc     = 1'b1;
    w_en_fd     = 1'b1;
    w_clr_fd    = 1'b0;
    w_en_de     = 1'b1;
    w_clr_de    = 1'b0;
    w_en_em     = 1'b1;
    w_en_mw     = 1'b1;
    w_flush_inc = 1'b0;
    case (r_st)
      DISCARD: begin
        w_en_pc  = 1'b0;
        w_clr_fd = 1'b1;
        if (w_dmem_wait) begin
          w_en_de = 1'b0;
          w_en_em = 1'b0;
          w_en_mw = 1'b0;
        end
        if (bus.imem_ready_f) w_st_nxt = RUN;
      end
      default: begin
        // RUN and MEM_WAIT share rules: MEM_WAIT releases into RUN behaviour the cycle dmem is ready.
        if (w_dmem_wait) begin
          w_en_pc  = 1'b0;
          w_en_fd  = 1'b0;
          w_en_de  = 1'b0;
          w_en_em  = 1'b0;
          w_en_mw  = 1'b0;
          w_st_nxt = MEM_WAIT;
        end else begin
          w_st_nxt = RUN;
          if (bus.pcsrc_e) begin
            w_clr_fd    = 1'b1;
            w_clr_de    = 1'b1;
            w_flush_inc = 1'b1;
            if (!bus.imem_ready_f) w_st_nxt = DISCARD;
          end else if (w_lu_haz) begin
            w_en_pc  = 1'b0;
            w_en_fd  = 1'b0;
            w_clr_de = 1'b1;
          end else if (!bus.imem_ready_f) begin
            w_en_pc  = 1'b0;
            w_clr_fd = 1'b1;
          end
        end
      end
    endcase
  end

  assign bus.en_pc   = rst_n & w_en_pc;
  assign bus.en_fd   = rst_n & w_en_fd;
  assign bus.clr_fd  = rst_n & w_clr_fd;
  assign bus.en_de   = rst_n & w_en_de;
  assign bus.clr_de  = rst_n & w_clr_de;
  assign bus.en_em   = rst_n & w_en_em;
  assign bus.clr_em  = 1'b0;
  assign bus.en_mw   = rst_n & w_en_mw;
  assign bus.clr_mw  = 1'b0;
  assign bus.fwd_a_e = rst_n ? w_fwd_a : FWD_NONE;
  assign bus.fwd_b_e = rst_n ? w_fwd_b : FWD_NONE;

  // A full freeze always holds F/D, so en_fd=0 covers both stall kinds.
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!w_en_fd),
    .count (bus.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_flush_inc),
    .count (bus.flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       regwrite_e, regwrite_m, regwrite_w;
  logic       memread_e, pcsrc_e, imem_ready_f, dmem_req_m, dmem_ready_m;

  int n_cmp = 0;
  int n_bad = 0;

  // {en_pc, en_fd, clr_fd, en_de, clr_de, en_em, clr_em, en_mw, clr_mw}
  localparam logic [8:0] C_OFF    = 9'b000000000;
  localparam logic [8:0] C_RUN    = 9'b110101010;
  localparam logic [8:0] C_LU     = 9'b000111010;
  localparam logic [8:0] C_FLUSH  = 9'b111111010;
  localparam logic [8:0] C_FBUB   = 9'b011101010;
  localparam logic [8:0] C_DFRZ   = 9'b011000000;

  pipe_hazard_ctrl_if #(.CNT_W(32)) bus32 ();
  pipe_hazard_ctrl_if #(.CNT_W(4))  bus4 ();

  assign bus32.rs1_d = rs1_d;  assign bus4.rs1_d = rs1_d;
  assign bus32.rs2_d = rs2_d;  assign bus4.rs2_d = rs2_d;
  assign bus32.rs1_e = rs1_e;  assign bus4.rs1_e = rs1_e;
  assign bus32.rs2_e = rs2_e;  assign bus4.rs2_e = rs2_e;
  assign bus32.rd_e  = rd_e;   assign bus4.rd_e  = rd_e;
  assign bus32.rd_m  = rd_m;   assign bus4.rd_m  = rd_m;
  assign bus32.rd_w  = rd_w;   assign bus4.rd_w  = rd_w;
  assign bus32.regwrite_e = regwrite_e;  assign bus4.regwrite_e = regwrite_e;
  assign bus32.regwrite_m = regwrite_m;  assign bus4.regwrite_m = regwrite_m;
  assign bus32.regwrite_w = regwrite_w;  assign bus4.regwrite_w = regwrite_w;
  assign bus32.memread_e  = memread_e;   assign bus4.memread_e  = memread_e;
  assign bus32.pcsrc_e    = pcsrc_e;     assign bus4.pcsrc_e    = pcsrc_e;
  assign bus32.imem_ready_f = imem_ready_f;  assign bus4.imem_ready_f = imem_ready_f;
  assign bus32.dmem_req_m   = dmem_req_m;    assign bus4.dmem_req_m   = dmem_req_m;
  assign bus32.dmem_ready_m = dmem_ready_m;  assign bus4.dmem_ready_m = dmem_ready_m;

  pipe_hazard_ctrl #(.CNT_W(32), .FWD_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32)
  );

  pipe_hazard_ctrl #(.CNT_W(4), .FWD_EN(1'b1)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  wire [8:0] ctl  = {bus32.en_pc, bus32.en_fd, bus32.clr_fd, bus32.en_de, bus32.clr_de,
                     bus32.en_em, bus32.clr_em, bus32.en_mw, bus32.clr_mw};
  wire [8:0] ctl4 = {bus4.en_pc, bus4.en_fd, bus4.clr_fd, bus4.en_de, bus4.clr_de,
                     bus4.en_em, bus4.clr_em, bus4.en_mw, bus4.clr_mw};

  task automatic set_idle();
    rs1_d = 5'd1; rs2_d = 5'd2; rs1_e = 5'd6; rs2_e = 5'd7;
    rd_e = 5'd10; rd_m = 5'd11; rd_w = 5'd12;
    regwrite_e = 1'b0; regwrite_m = 1'b0; regwrite_w = 1'b0;
    memread_e = 1'b0; pcsrc_e = 1'b0; imem_ready_f = 1'b1;
    dmem_req_m = 1'b0; dmem_ready_m = 1'b0;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    pcsrc_e = 1'b1; rs1_e = 5'd11; regwrite_m = 1'b1;
    @(negedge clk);
    n_cmp++; if (ctl !== C_OFF) begin n_bad++; $display("FAIL reset_ctl: got %b exp %b", ctl, C_OFF); end
    n_cmp++; if (bus32.fwd_a_e !== 2'b00) begin n_bad++; $display("FAIL reset_fwd: got %b exp 00", bus32.fwd_a_e); end
    n_cmp++; if (bus32.stall_cnt !== 32'd0 || bus32.flush_cnt !== 32'd0) begin
      n_bad++; $display("FAIL reset_cnt: got %0d/%0d exp 0/0", bus32.stall_cnt, bus32.flush_cnt); end
    next_cycle();
    set_idle();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (ctl !== C_RUN) begin n_bad++; $display("FAIL run_default: got %b exp %b", ctl, C_RUN); end
  endtask

  task automatic test_load_use();
    do_reset();
    memread_e = 1'b1; regwrite_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5;
    @(negedge clk);
    n_cmp++; if (ctl !== C_LU) begin n_bad++; $display("FAIL lu_stall: got %b exp %b", ctl, C_LU); end
    next_cycle();
    memread_e = 1'b0; regwrite_e = 1'b0; rd_e = 5'd0;
    @(negedge clk);
    n_cmp++; if (ctl !== C_RUN) begin n_bad++; $display("FAIL lu_release: got %b exp %b", ctl, C_RUN); end
    n_cmp++; if (bus32.stall_cnt !== 32'd1) begin n_bad++; $display("FAIL lu_stall_cnt: got %0d exp 1", bus32.stall_cnt); end
    memread_e = 1'b1; rd_e = 5'd9; rs1_d = 5'd1; rs2_d = 5'd9;
    @(negedge clk);
    n_cmp++; if (ctl !== C_LU) begin n_bad++; $display("FAIL lu_rs2: got %b exp %b", ctl, C_LU); end
    rd_e = 5'd0; rs1_d = 5'd0; rs2_d = 5'd0;
    @(negedge clk);
    n_cmp++; if (ctl !== C_RUN) begin n_bad++; $display("FAIL lu_x0: got %b exp %b", ctl, C_RUN); end
    next_cycle();
  endtask

  task automatic test_forwarding();
    do_reset();
    rs1_e = 5'd3; rd_m = 5'd3; regwrite_m = 1'b1; rd_w = 5'd3; regwrite_w = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus32.fwd_a_e !== 2'b10) begin n_bad++; $display("FAIL fwd_m_prio: got %b exp 10", bus32.fwd_a_e); end
    rd_m = 5'd0;
    @(negedge clk);
    n_cmp++; if (bus32.fwd_a_e !== 2'b01) begin n_bad++; $display("FAIL fwd_w: got %b exp 01", bus32.fwd_a_e); end
    rs1_e = 5'd0; rd_w = 5'd0;
    @(negedge clk);
    n_cmp++; if (bus32.fwd_a_e !== 2'b00) begin n_bad++; $display("FAIL fwd_x0: got %b exp 00", bus32.fwd_a_e); end
    rs2_e = 5'd8; rd_m = 5'd8; regwrite_m = 1'b0; rd_w = 5'd8; regwrite_w = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus32.fwd_b_e !== 2'b01) begin n_bad++; $display("FAIL fwd_b_nowe_m: got %b exp 01", bus32.fwd_b_e); end
    n_cmp++; if (ctl !== C_RUN) begin n_bad++; $display("FAIL fwd_no_stall: got %b exp %b", ctl, C_RUN); end
    next_cycle();
  endtask

  task automatic test_branch_over_lu();
    do_reset();
    memread_e = 1'b1; regwrite_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5; pcsrc_e = 1'b1;
    @(negedge clk);
    n_cmp++; if (ctl !== C_FLUSH) begin n_bad++; $display("FAIL br_lu_ctl: got %b exp %b", ctl, C_FLUSH); end
    next_cycle();
    set_idle();
    @(negedge clk);
    n_cmp++; if (bus32.flush_cnt !== 32'd1) begin n_bad++; $display("FAIL br_flush_cnt: got %0d exp 1", bus32.flush_cnt); end
    n_cmp++; if (bus32.stall_cnt !== 32'd0) begin n_bad++; $display("FAIL br_stall_cnt: got %0d exp 0", bus32.stall_cnt); end
    n_cmp++; if (ctl !== C_RUN) begin n_bad++; $display("FAIL br_after: got %b exp %b", ctl, C_RUN); end
    next_cycle();
  endtask

  task automatic test_dmem_wait();
    do_reset();
    dmem_req_m = 1'b1; dmem_ready_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (ctl !== C_OFF) begin n_bad++; $display("FAIL dmem_freeze%0d: got %b exp %b", i, ctl, C_OFF); end
      next_cycle();
    end
    dmem_ready_m = 1'b1;
    @(negedge clk);
    n_cmp++; if (ctl !== C_RUN) begin n_bad++; $display("FAIL dmem_release: got %b exp %b", ctl, C_RUN); end
    next_cycle();
    set_idle();
    @(negedge clk);
    n_cmp++; if (bus32.stall_cnt !== 32'd3) begin n_bad++; $display("FAIL dmem_stall_cnt: got %0d exp 3", bus32.stall_cnt); end
    n_cmp++; if (ctl !== C_RUN) begin n_bad++; $display("FAIL dmem_run: got %b exp %b", ctl, C_RUN); end
    next_cycle();
  endtask

  task automatic test_discard();
    logic [8:0] exp_seq [4];
    exp_seq[0] = C_FLUSH; exp_seq[1] = C_FBUB; exp_seq[2] = C_FBUB; exp_seq[3] = C_RUN;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pcsrc_e      = (i == 0);
      imem_ready_f = (i >= 2);
      @(negedge clk);
      n_cmp++; if (ctl !== exp_seq[i]) begin n_bad++; $display("FAIL discard_c%0d: got %b exp %b", i, ctl, exp_seq[i]); end
      next_cycle();
    end
    n_cmp++; if (bus32.flush_cnt !== 32'd1 || bus32.stall_cnt !== 32'd0) begin
      n_bad++; $display("FAIL discard_cnts: got %0d/%0d exp 1/0", bus32.flush_cnt, bus32.stall_cnt); end
    pcsrc_e = 1'b1; imem_ready_f = 1'b0;
    next_cycle();
    pcsrc_e = 1'b0; dmem_req_m = 1'b1; dmem_ready_m = 1'b0;
    @(negedge clk);
    n_cmp++; if (ctl !== C_DFRZ) begin n_bad++; $display("FAIL discard_dmem: got %b exp %b", ctl, C_DFRZ); end
    next_cycle();
    dmem_ready_m = 1'b1; imem_ready_f = 1'b1;
    @(negedge clk);
    n_cmp++; if (ctl !== C_FBUB) begin n_bad++; $display("FAIL discard_drop: got %b exp %b", ctl, C_FBUB); end
    next_cycle();
    set_idle();
    @(negedge clk);
    n_cmp++; if (ctl !== C_RUN) begin n_bad++; $display("FAIL discard_exit: got %b exp %b", ctl, C_RUN); end
    next_cycle();
  endtask

  task automatic test_saturation();
    do_reset();
    memread_e = 1'b1; regwrite_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5;
    for (int i = 0; i < 20; i++) next_cycle();
    set_idle();
    @(negedge clk);
    n_cmp++; if (bus4.stall_cnt !== 4'hF) begin n_bad++; $display("FAIL sat_stall4: got %h exp F", bus4.stall_cnt); end
    n_cmp++; if (bus32.stall_cnt !== 32'd20) begin n_bad++; $display("FAIL sat_stall32: got %0d exp 20", bus32.stall_cnt); end
    dmem_req_m = 1'b1; dmem_ready_m = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_cmp++; if (ctl4 !== C_OFF) begin n_bad++; $display("FAIL sat_memwait: got %b exp %b", ctl4, C_OFF); end
    n_cmp++; if (bus4.stall_cnt !== 4'hF) begin n_bad++; $display("FAIL sat_hold: got %h exp F", bus4.stall_cnt); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus4.stall_cnt !== 4'h0 || bus4.flush_cnt !== 4'h0) begin
      n_bad++; $display("FAIL async_rst_cnt: got %h/%h exp 0/0", bus4.stall_cnt, bus4.flush_cnt); end
    n_cmp++; if (ctl4 !== C_OFF) begin n_bad++; $display("FAIL async_rst_ctl: got %b exp %b", ctl4, C_OFF); end
    next_cycle();
    set_idle();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (ctl4 !== C_RUN) begin n_bad++; $display("FAIL rst_resume_run: got %b exp %b", ctl4, C_RUN); end
    pcsrc_e = 1'b1; imem_ready_f = 1'b0;
    next_cycle();
    pcsrc_e = 1'b0; imem_ready_f = 1'b1;
    @(negedge clk);
    n_cmp++; if (ctl4 !== C_FBUB) begin n_bad++; $display("FAIL rst_then_discard: got %b exp %b", ctl4, C_FBUB); end
    n_cmp++; if (bus4.flush_cnt !== 4'd1) begin n_bad++; $display("FAIL rst_flush4: got %0d exp 1", bus4.flush_cnt); end
    next_cycle();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_load_use();
    test_forwarding();
    test_branch_over_lu();
    test_dmem_wait();
    test_discard();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
